// File: rtl/vx_cache_flush_walker_pkg.sv
// Shared definitions for the cache flush walker.
//
// Contents:
//   walker_state_t : walker FSM states (init sweep, idle, flush sweep,
//                    writeback drain, completion response)
//   calc_lines     : lines per bank/way for the given cache geometry
//   calc_lsb       : line-index width (never narrower than one bit)
//   calc_wsb       : way-index width (never narrower than one bit)
package vx_cache_flush_walker_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_FLUSH,
    ST_DRAIN,
    ST_RESP
  } walker_state_t;

  function automatic int calc_lines(input int cache_size, input int line_size,
                                    input int num_banks, input int num_ways);
    return cache_size / (line_size * num_banks * num_ways);
  endfunction

  // A single-line or single-way cache still needs a one-bit counter so the
  // index ports and registers never collapse to zero width.
  function automatic int calc_lsb(input int lines);
    int w;
    w = $clog2(lines);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int calc_wsb(input int num_ways);
    int w;
    w = $clog2(num_ways);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vx_cache_flush_walker.sv
// Cache flush walker.
//
// After reset it sweeps every line with an invalidate-all-ways op so the tag
// store starts clean, then waits for a core flush request. A flush visits
// every (line, way) pair in order, way fastest, emitting one flush-line op
// per pair. After the last op is taken it waits for the writeback queue to
// empty and then reports completion.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   flush_req_valid   : core asks for a full flush
//   flush_req_ready   : request accepted (only while idle)
//   flush_rsp_valid   : flush finished, held until flush_rsp_ready
//   flush_rsp_ready   : completion consumed
//   out_valid         : walker op presented to the tag stage
//   out_ready         : tag stage accepts the op
//   out_init          : op is invalidate-all-ways
//   out_flush_line    : op is flush-one-way
//   out_way_sel       : one-hot way for flush ops, zero for init ops
//   out_line_sel      : line index of the op
//   wb_empty          : writeback/eviction queue is empty
//   busy              : blocks core requests into the bank (all but idle)
module vx_cache_flush_walker
  import vx_cache_flush_walker_pkg::*;
#(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_SIZE  = 16,
  parameter int NUM_BANKS  = 1,
  parameter int NUM_WAYS   = 1,
  localparam int LINES = calc_lines(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS),
  localparam int LSB   = calc_lsb(LINES),
  localparam int WSB   = calc_wsb(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_req_valid,
  output logic                flush_req_ready,
  output logic                flush_rsp_valid,
  input  logic                flush_rsp_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_init,
  output logic                out_flush_line,
  output logic [NUM_WAYS-1:0] out_way_sel,
  output logic [LSB-1:0]      out_line_sel,
  input  logic                wb_empty,
  output logic                busy
);

  localparam logic [LSB-1:0] LAST_LINE = LSB'(LINES - 1);
  localparam logic [WSB-1:0] LAST_WAY  = WSB'(NUM_WAYS - 1);

  walker_state_t  state, state_next;
  logic [LSB-1:0] line, line_next;
  logic [WSB-1:0] way, way_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      line  <= '0;
      way   <= '0;
    end else begin
      state <= state_next;
      line  <= line_next;
      way   <= way_next;
    end
  end

  // Counters only move on an accepted op, so every out_* signal is purely a
  // function of registered state and stays put while the tag stage stalls.
  always_comb begin
    state_next      = state;
    line_next       = line;
    way_next        = way;
    out_valid       = 1'b0;
    out_init        = 1'b0;
    out_flush_line  = 1'b0;
    out_way_sel     = '0;
    flush_req_ready = 1'b0;
    flush_rsp_valid = 1'b0;
    busy            = 1'b1;

    case (state)
      ST_INIT: begin
        out_valid = 1'b1;
        out_init  = 1'b1;
        if (out_ready) begin
          if (line == LAST_LINE) begin
            line_next  = '0;
            state_next = ST_IDLE;
          end else begin
            line_next = line + 1'b1;
          end
        end
      end

      ST_IDLE: begin
        busy            = 1'b0;
        flush_req_ready = 1'b1;
        if (flush_req_valid) begin
          line_next  = '0;
          way_next   = '0;
          state_next = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        out_valid      = 1'b1;
        out_flush_line = 1'b1;
        for (int i = 0; i < NUM_WAYS; i++) begin
          out_way_sel[i] = (way == WSB'(i));
        end
        if (out_ready) begin
          if (way == LAST_WAY) begin
            way_next = '0;
            if (line == LAST_LINE) begin
              line_next  = '0;
              state_next = ST_DRAIN;
            end else begin
              line_next = line + 1'b1;
            end
          end else begin
            way_next = way + 1'b1;
          end
        end
      end

      // wb_empty is sampled in the same cycle, so an already-empty queue
      // costs exactly one drain cycle.
      ST_DRAIN: begin
        if (wb_empty) begin
          state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        flush_rsp_valid = 1'b1;
        if (flush_rsp_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  assign out_line_sel = line;

endmodule

// File: tb/tb_vx_cache_flush_walker.sv
// Self-checking bench for vx_cache_flush_walker.
//
// Three instances share one set of input drivers:
//   dut_small : 2 lines x 2 ways, walked cycle by cycle from a vector table
//   dut_main  : 32 lines x 2 ways, long init/flush sequences
//   dut_one   : 64 lines x 1 way, single-way flush
// A select variable routes one of the two large instances onto obs_* for
// the shared sequence tasks.
module tb_vx_cache_flush_walker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic flush_req_valid = 1'b0;
  logic flush_rsp_ready = 1'b0;
  logic out_ready = 1'b0;
  logic wb_empty = 1'b1;

  int total = 0;
  int bad = 0;
  int sel = 0;

  logic       s_req_ready, s_rsp_valid, s_valid, s_init, s_flush, s_busy;
  logic [1:0] s_way;
  logic [0:0] s_line;

  logic       m_req_ready, m_rsp_valid, m_valid, m_init, m_flush, m_busy;
  logic [1:0] m_way;
  logic [4:0] m_line;

  logic       o_req_ready, o_rsp_valid, o_valid, o_init, o_flush, o_busy;
  logic [0:0] o_way;
  logic [5:0] o_line;

  vx_cache_flush_walker #(
    .CACHE_SIZE(64), .LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(2)
  ) dut_small (
    .clk(clk), .reset(reset),
    .flush_req_valid(flush_req_valid), .flush_req_ready(s_req_ready),
    .flush_rsp_valid(s_rsp_valid), .flush_rsp_ready(flush_rsp_ready),
    .out_valid(s_valid), .out_ready(out_ready),
    .out_init(s_init), .out_flush_line(s_flush),
    .out_way_sel(s_way), .out_line_sel(s_line),
    .wb_empty(wb_empty), .busy(s_busy)
  );

  vx_cache_flush_walker #(
    .CACHE_SIZE(1024), .LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(2)
  ) dut_main (
    .clk(clk), .reset(reset),
    .flush_req_valid(flush_req_valid), .flush_req_ready(m_req_ready),
    .flush_rsp_valid(m_rsp_valid), .flush_rsp_ready(flush_rsp_ready),
    .out_valid(m_valid), .out_ready(out_ready),
    .out_init(m_init), .out_flush_line(m_flush),
    .out_way_sel(m_way), .out_line_sel(m_line),
    .wb_empty(wb_empty), .busy(m_busy)
  );

  vx_cache_flush_walker #(
    .CACHE_SIZE(1024), .LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(1)
  ) dut_one (
    .clk(clk), .reset(reset),
    .flush_req_valid(flush_req_valid), .flush_req_ready(o_req_ready),
    .flush_rsp_valid(o_rsp_valid), .flush_rsp_ready(flush_rsp_ready),
    .out_valid(o_valid), .out_ready(out_ready),
    .out_init(o_init), .out_flush_line(o_flush),
    .out_way_sel(o_way), .out_line_sel(o_line),
    .wb_empty(wb_empty), .busy(o_busy)
  );

  logic [31:0] obs_valid, obs_init, obs_flush, obs_way, obs_line;
  logic [31:0] obs_busy, obs_rq, obs_rs;

  always_comb begin
    obs_valid = '0;
    obs_init  = '0;
    obs_flush = '0;
    obs_way   = '0;
    obs_line  = '0;
    obs_busy  = '0;
    obs_rq    = '0;
    obs_rs    = '0;
    if (sel == 0) begin
      obs_valid = 32'(m_valid);
      obs_init  = 32'(m_init);
      obs_flush = 32'(m_flush);
      obs_way   = 32'(m_way);
      obs_line  = 32'(m_line);
      obs_busy  = 32'(m_busy);
      obs_rq    = 32'(m_req_ready);
      obs_rs    = 32'(m_rsp_valid);
    end else begin
      obs_valid = 32'(o_valid);
      obs_init  = 32'(o_init);
      obs_flush = 32'(o_flush);
      obs_way   = 32'(o_way);
      obs_line  = 32'(o_line);
      obs_busy  = 32'(o_busy);
      obs_rq    = 32'(o_req_ready);
      obs_rs    = 32'(o_rsp_valid);
    end
  end

  // in  = {reset, flush_req_valid, flush_rsp_ready, out_ready, wb_empty}
  // exp = {out_valid, out_init, out_flush_line, way_sel[1:0], line_sel,
  //        busy, flush_req_ready, flush_rsp_valid}
  typedef struct {
    logic [4:0] in;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    {reset, flush_req_valid, flush_rsp_ready, out_ready, wb_empty} = v.in;
  endtask

  // Holds reset for one edge, then counts init ops on the selected DUT.
  task automatic run_init(input int exp_lines);
    int ops;
    int cyc;
    ops = 0;
    cyc = 0;
    flush_req_valid = 1'b0;
    flush_rsp_ready = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("reset.out_valid", obs_valid, 1);
    check_output("reset.out_init", obs_init, 1);
    check_output("reset.out_flush_line", obs_flush, 0);
    check_output("reset.out_line_sel", obs_line, 0);
    check_output("reset.busy", obs_busy, 1);
    check_output("reset.flush_req_ready", obs_rq, 0);
    check_output("reset.flush_rsp_valid", obs_rs, 0);
    while (obs_valid == 1 && obs_init == 1 && cyc < 4 * exp_lines) begin
      check_output("init.out_line_sel", obs_line, 32'(ops));
      check_output("init.out_way_sel", obs_way, 0);
      check_output("init.flush_rsp_valid", obs_rs, 0);
      ops++;
      cyc++;
      step();
    end
    check_output("init.op_count", 32'(ops), 32'(exp_lines));
    check_output("idle.busy", obs_busy, 0);
    check_output("idle.flush_req_ready", obs_rq, 1);
    check_output("idle.out_valid", obs_valid, 0);
  endtask

  // Issues a flush request and follows the op stream until the walker
  // leaves the flush sweep. Op k must address line k/ways, way k%ways.
  task automatic run_flush(input int exp_ops, input int ways, input bit toggle);
    int ops;
    int cyc;
    bit stalled;
    logic [31:0] prev_line, prev_way;
    ops = 0;
    cyc = 0;
    stalled = 1'b0;
    prev_line = '0;
    prev_way = '0;
    out_ready = 1'b1;
    flush_req_valid = 1'b1;
    step();
    flush_req_valid = 1'b0;
    while (obs_valid == 1 && cyc < 1000) begin
      out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      check_output("flush.out_flush_line", obs_flush, 1);
      check_output("flush.out_init", obs_init, 0);
      check_output("flush.busy", obs_busy, 1);
      check_output("flush.flush_req_ready", obs_rq, 0);
      if (stalled) begin
        check_output("stall.line_stable", obs_line, prev_line);
        check_output("stall.way_stable", obs_way, prev_way);
      end
      check_output("flush.out_line_sel", obs_line, 32'(ops / ways));
      check_output("flush.out_way_sel", obs_way, 32'(1) << (ops % ways));
      prev_line = obs_line;
      prev_way = obs_way;
      stalled = !out_ready;
      if (out_ready) ops++;
      cyc++;
      step();
    end
    out_ready = 1'b1;
    check_output("flush.bounded", 32'(cyc < 1000), 1);
    check_output("flush.op_count", 32'(ops), 32'(exp_ops));
  endtask

  initial begin
    vecs[0]  = '{5'b1_0_0_1_1, 9'b1_1_0_00_0_1_0_0};
    vecs[1]  = '{5'b0_0_0_0_1, 9'b1_1_0_00_0_1_0_0};
    vecs[2]  = '{5'b0_0_0_1_1, 9'b1_1_0_00_0_1_0_0};
    vecs[3]  = '{5'b0_0_0_1_1, 9'b1_1_0_00_1_1_0_0};
    vecs[4]  = '{5'b0_0_0_1_1, 9'b0_0_0_00_0_0_1_0};
    vecs[5]  = '{5'b0_1_0_0_1, 9'b0_0_0_00_0_0_1_0};
    vecs[6]  = '{5'b0_1_0_0_1, 9'b1_0_1_01_0_1_0_0};
    vecs[7]  = '{5'b0_1_0_1_1, 9'b1_0_1_01_0_1_0_0};
    vecs[8]  = '{5'b0_0_0_1_1, 9'b1_0_1_10_0_1_0_0};
    vecs[9]  = '{5'b0_0_0_1_1, 9'b1_0_1_01_1_1_0_0};
    vecs[10] = '{5'b0_0_0_1_0, 9'b1_0_1_10_1_1_0_0};
    vecs[11] = '{5'b0_0_0_1_0, 9'b0_0_0_00_0_1_0_0};
    vecs[12] = '{5'b0_0_0_1_1, 9'b0_0_0_00_0_1_0_0};
    vecs[13] = '{5'b0_0_0_1_1, 9'b0_0_0_00_0_1_0_1};
    vecs[14] = '{5'b0_1_1_1_1, 9'b0_0_0_00_0_1_0_1};
    vecs[15] = '{5'b0_1_0_1_1, 9'b0_0_0_00_0_0_1_0};
    vecs[16] = '{5'b0_0_0_1_1, 9'b1_0_1_01_0_1_0_0};
    vecs[17] = '{5'b1_0_0_1_1, 9'b1_0_1_10_0_1_0_0};
    vecs[18] = '{5'b0_0_0_0_1, 9'b1_1_0_00_0_1_0_0};

    // Small instance: whole lifecycle, one table row per cycle.
    reset = 1'b1;
    step();
    for (int i = 0; i < 19; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("v%0d.out_valid", i), 32'(s_valid), 32'(vecs[i].exp[8]));
      check_output($sformatf("v%0d.out_init", i), 32'(s_init), 32'(vecs[i].exp[7]));
      check_output($sformatf("v%0d.out_flush_line", i), 32'(s_flush), 32'(vecs[i].exp[6]));
      if (vecs[i].exp[8]) begin
        check_output($sformatf("v%0d.out_way_sel", i), 32'(s_way), 32'(vecs[i].exp[5:4]));
        check_output($sformatf("v%0d.out_line_sel", i), 32'(s_line), 32'(vecs[i].exp[3]));
      end
      check_output($sformatf("v%0d.busy", i), 32'(s_busy), 32'(vecs[i].exp[2]));
      check_output($sformatf("v%0d.flush_req_ready", i), 32'(s_req_ready), 32'(vecs[i].exp[1]));
      check_output($sformatf("v%0d.flush_rsp_valid", i), 32'(s_rsp_valid), 32'(vecs[i].exp[0]));
      step();
    end

    // Main instance: init sweep, then a flush with everything ready.
    sel = 0;
    wb_empty = 1'b1;
    run_init(32);
    run_flush(64, 2, 1'b0);
    check_output("drain1.flush_rsp_valid", obs_rs, 0);
    check_output("drain1.busy", obs_busy, 1);
    step();
    check_output("resp1.flush_rsp_valid", obs_rs, 1);
    check_output("resp1.busy", obs_busy, 1);
    flush_rsp_ready = 1'b1;
    step();
    flush_rsp_ready = 1'b0;
    check_output("idle1.flush_rsp_valid", obs_rs, 0);
    check_output("idle1.flush_req_ready", obs_rq, 1);
    check_output("idle1.busy", obs_busy, 0);

    // Stalling tag stage, then a writeback queue that stays busy.
    wb_empty = 1'b0;
    run_flush(64, 2, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check_output("drain2.flush_rsp_valid", obs_rs, 0);
      check_output("drain2.out_valid", obs_valid, 0);
      check_output("drain2.busy", obs_busy, 1);
      step();
    end
    wb_empty = 1'b1;
    check_output("drain2.last_wait", obs_rs, 0);
    step();
    check_output("resp2.flush_rsp_valid", obs_rs, 1);
    flush_rsp_ready = 1'b1;
    step();
    flush_rsp_ready = 1'b0;
    check_output("idle2.busy", obs_busy, 0);

    // Reset in the middle of a flush restarts the init sweep.
    begin
      int cyc;
      cyc = 0;
      out_ready = 1'b1;
      flush_req_valid = 1'b1;
      step();
      flush_req_valid = 1'b0;
      while (obs_line != 7 && cyc < 200) begin
        cyc++;
        step();
      end
      check_output("midflush.reached_line7", obs_line, 7);
      check_output("midflush.in_flush", obs_flush, 1);
    end
    run_init(32);
    check_output("after_reset.flush_rsp_valid", obs_rs, 0);

    // Single-way instance: 64 lines, way select always 1.
    sel = 1;
    wb_empty = 1'b1;
    run_init(64);
    run_flush(64, 1, 1'b0);
    step();
    check_output("one_way.flush_rsp_valid", obs_rs, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
